// File: rtl/ss_seq.sv
// Save-state sequencer: walks mapper registers 0..LAST_ADDR,
// dumping them to a buffer RAM or restoring them on m2 falling edges.
`timescale 1ns/1ps
module ss_seq #(
    parameter logic [7:0] LAST_ADDR = 8'd127,
    parameter int         SETTLE    = 2,
    parameter int         TIMEOUT   = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       m2,
    input  logic       start_save,
    input  logic       start_load,
    input  logic       abort,
    output logic       ss_act,
    output logic       ss_we,
    output logic [7:0] ss_addr,
    output logic [7:0] ss_wdat,
    input  logic [7:0] ss_rdat,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdat,
    output logic       buf_we,
    input  logic [7:0] buf_rdat,
    output logic       busy,
    output logic       done,
    output logic       err
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_SET   = 3'd1;
    localparam logic [2:0] RD_CAP   = 3'd2;
    localparam logic [2:0] WR_FETCH = 3'd3;
    localparam logic [2:0] WR_LATCH = 3'd4;
    localparam logic [2:0] WR_WAIT  = 3'd5;
    localparam logic [2:0] WR_REL   = 3'd6;
    localparam logic [2:0] FINISH   = 3'd7;

    localparam logic [15:0] SET_END = 16'(SETTLE - 1);
    localparam logic [15:0] TO_END  = 16'(TIMEOUT - 1);

    logic [2:0]  state;
    logic [15:0] cnt;
    logic        m2_s1;
    logic        m2_s2;
    logic        m2_fall;
    logic        at_last;

    assign m2_fall = m2_s2 & ~m2_s1;
    assign at_last = (ss_addr == LAST_ADDR);
    assign busy    = (state != IDLE);
    assign ss_act  = busy;
    assign done    = (state == FINISH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            m2_s1    <= 1'b0;
            m2_s2    <= 1'b0;
            ss_we    <= 1'b0;
            ss_addr  <= '0;
            ss_wdat  <= '0;
            buf_addr <= '0;
            buf_wdat <= '0;
            buf_we   <= 1'b0;
            err      <= 1'b0;
        end else begin
            m2_s1 <= m2;
            m2_s2 <= m2_s1;
            if (abort && state != IDLE) begin
                state  <= IDLE;
                ss_we  <= 1'b0;
                buf_we <= 1'b0;
            end else begin
                unique case (state)
                    IDLE: begin
                        if (start_save) begin
                            state   <= RD_SET;
                            ss_addr <= '0;
                            cnt     <= '0;
                            err     <= 1'b0;
                        end else if (start_load) begin
                            state    <= WR_FETCH;
                            ss_addr  <= '0;
                            buf_addr <= '0;
                            err      <= 1'b0;
                        end
                    end
                    // ss_rdat is sampled only after the address has settled
                    RD_SET: begin
                        if (cnt == SET_END) begin
                            state    <= RD_CAP;
                            buf_we   <= 1'b1;
                            buf_addr <= ss_addr;
                            buf_wdat <= ss_rdat;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    RD_CAP: begin
                        buf_we <= 1'b0;
                        if (at_last) begin
                            state <= FINISH;
                        end else begin
                            state   <= RD_SET;
                            ss_addr <= ss_addr + 8'd1;
                            cnt     <= '0;
                        end
                    end
                    WR_FETCH: state <= WR_LATCH;
                    WR_LATCH: begin
                        ss_wdat <= buf_rdat;
                        ss_we   <= 1'b1;
                        cnt     <= '0;
                        state   <= WR_WAIT;
                    end
                    WR_WAIT: begin
                        if (m2_fall) begin
                            ss_we <= 1'b0;
                            state <= WR_REL;
                        end else if (cnt == TO_END) begin
                            ss_we <= 1'b0;
                            err   <= 1'b1;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 16'd1;
                        end
                    end
                    WR_REL: begin
                        if (at_last) begin
                            state <= FINISH;
                        end else begin
                            state    <= WR_FETCH;
                            ss_addr  <= ss_addr + 8'd1;
                            buf_addr <= ss_addr + 8'd1;
                        end
                    end
                    FINISH:  state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/ss_seq.md
SS_SEQ -- requirements
Module: ss_seq

Interface
REQ-001 Parameter LAST_ADDR, default 8'd127: final save-state register index walked; the sequence covers 0..LAST_ADDR inclusive.
REQ-002 Parameter SETTLE, default 2: clk cycles ss_addr is held before ss_rdat is sampled; minimum 1.
REQ-003 Parameter TIMEOUT, default 255: clk cycles to wait for an m2 falling edge before aborting a load.
REQ-004 clk  in  1  system clock; the only clock; all state changes on its rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 m2  in  1  CPU M2 from the bus, asynchronous to clk; mapper registers capture save-state writes on its falling edge.
REQ-007 start_save  in  1  one-cycle pulse; dump mapper registers to the buffer.
REQ-008 start_load  in  1  one-cycle pulse; restore mapper registers from the buffer.
REQ-009 abort  in  1  level; terminates any sequence.
REQ-010 ss_act  out  1  save-state bus owned; mapper ignores normal CPU writes.
REQ-011 ss_we  out  1  save-state write strobe.
REQ-012 ss_addr  out  8  mapper register index.
REQ-013 ss_wdat  out  8  write data presented on the mapper data input.
REQ-014 ss_rdat  in  8  mapper readback, combinational from ss_addr.
REQ-015 buf_addr  out  8  buffer RAM address.
REQ-016 buf_wdat  out  8  buffer write data.
REQ-017 buf_we  out  1  buffer write enable, one cycle per byte.
REQ-018 buf_rdat  in  8  buffer read data, valid exactly 1 clk after buf_addr changes.
REQ-019 busy  out  1  sequence in progress.
REQ-020 done  out  1  one-cycle pulse on normal completion.
REQ-021 err  out  1  sticky load-timeout flag; cleared by the next accepted start.

Function
REQ-022 m2 SHALL pass through a 2-flop synchronizer; a falling edge is detected as sync stage 2 high and stage 1 low, giving 1 clk of detection.
REQ-023 States: IDLE, RD_SET, RD_CAP, WR_FETCH, WR_LATCH, WR_WAIT, WR_REL, FINISH.
REQ-024 IDLE: start_save -> RD_SET with ss_addr=0. start_load -> WR_FETCH with ss_addr=0 and buf_addr=0. Both in the same cycle: save wins. Starts are ignored while busy=1.
REQ-025 busy SHALL be 1 in every state except IDLE; ss_act SHALL equal busy.
REQ-026 RD_SET: ss_we=0; hold for SETTLE cycles, then go to RD_CAP.
REQ-027 RD_CAP (1 cycle): buf_we=1, buf_addr=ss_addr, buf_wdat=ss_rdat. If ss_addr==LAST_ADDR go to FINISH; otherwise increment ss_addr and return to RD_SET.
REQ-028 WR_FETCH (1 cycle): buf_addr=ss_addr.
REQ-029 WR_LATCH: ss_wdat<=buf_rdat and ss_we<=1; clear the timeout counter; go to WR_WAIT.
REQ-030 WR_WAIT: hold ss_addr, ss_wdat and ss_we until a synchronized m2 falling edge is detected; then ss_we<=0 and go to WR_REL.
REQ-031 WR_REL (1 cycle, address held): if ss_addr==LAST_ADDR go to FINISH; otherwise increment and go to WR_FETCH.
REQ-032 Each byte's write SHALL span exactly one m2 falling edge, giving the mapper one capture per address.
REQ-033 Timeout: if TIMEOUT cycles elapse in WR_WAIT with no edge, set err=1, ss_we=0, and go to IDLE without pulsing done.
REQ-034 FINISH (1 cycle): done=1, ss_act=0 on the following cycle, then IDLE. ss_addr is not cleared.
REQ-035 abort=1 in any non-IDLE state: next cycle ss_we=0, buf_we=0, state IDLE, no done. abort in IDLE: no effect.
REQ-036 Address arithmetic is 8-bit; the terminal compare precedes the increment, so LAST_ADDR=255 ends without wrapping.
REQ-037 buf_we SHALL be 0 outside RD_CAP; ss_we SHALL be 0 outside WR_LATCH exit through WR_WAIT.

Reset
REQ-038 On rst: state IDLE; ss_act, ss_we, buf_we, busy, done and err = 0; ss_addr, ss_wdat, buf_addr and buf_wdat = 0; synchronizer flops = 0.
REQ-039 rst asserted mid-sequence SHALL drop ss_we and ss_act immediately (asynchronously), with no further buffer or mapper writes.

Verification
REQ-040 Save, LAST_ADDR=16, ss_rdat=ss_addr^8'hA5 -> 17 buf_we pulses, buf[n]=n^A5, one done, busy high throughout.
REQ-041 Load, buffer n->8'h10+n, m2 period 12 clk -> 17 ss_we windows, each containing exactly one m2 fall, ss_wdat=10+n, done pulse.
REQ-042 Load with m2 held high -> err=1 after 255 cycles in WR_WAIT, ss_we=0, no done; the next start_save clears err.
REQ-043 start_save and start_load in the same cycle -> save runs; a start_load during busy is ignored.
REQ-044 abort at byte 5 of a load -> ss_we=0 next cycle, IDLE, no done; rst pulse mid-save -> all outputs 0 asynchronously.
